// File: rtl/bsmod_pkg.sv
// Shared types and elaboration-time helpers for the bit-serial pseudo-Mersenne
// modular multiplier (p = 2^LEN - C).
package bsmod_pkg;

    typedef enum logic {StIdle, StAcc} acc_state_e;

    // Cycle offset from the isync cycle to the cycle carrying result bit 0.
    function automatic int unsigned lat_cycles(input int unsigned len);
        return len + 3;
    endfunction

    // Width of an H*C + L fold result with one bit of headroom.
    function automatic int unsigned fold_width(input int unsigned len, input int unsigned c);
        return len + $clog2(c + 1) + 1;
    endfunction

    // C must be small enough that two folds plus one subtract fully reduce.
    function automatic bit modulus_ok(input int unsigned len, input int unsigned c);
        if (len < 8 || len > 64) begin
            return 1'b0;
        end
        if (c == 0) begin
            return 1'b0;
        end
        return 64'(c) < (64'd1 << (len / 2 - 1));
    endfunction

endpackage

// File: rtl/bsmodmul_pm_if.sv
// Serial operand / serial result bundle of bsmodmul_pm.
interface bsmodmul_pm_if #(
    parameter int unsigned LEN = 24
) ();
    logic           a;
    logic [LEN-1:0] b;
    logic           isync;
    logic           q;
    logic           osync;
    logic           ovld;
    logic           ferr;

    modport master (output a, b, isync, input q, osync, ovld, ferr);
    modport slave  (input a, b, isync, output q, osync, ovld, ferr);
endinterface

// File: rtl/bsfold.sv
// One registered fold stage: P = H*2^LEN + L is replaced by H*C + L.
module bsfold
    import bsmod_pkg::*;
#(
    parameter int unsigned LEN = 24,
    parameter int unsigned C   = 3,
    parameter int unsigned IW  = fold_width(LEN, C)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_vld,
    input  logic [2*LEN-1:0] i_p,
    output logic             o_vld,
    output logic [IW-1:0]    o_p
);

    logic [IW-1:0] w_h;
    logic [IW-1:0] w_l;
    logic [IW-1:0] w_sum;
    logic          r_vld;
    logic [IW-1:0] r_p;

    // H*C + L < 2^LEN * (C+1) always fits in IW bits, so no bits are lost here.
    assign w_h   = IW'(i_p[2*LEN-1:LEN]);
    assign w_l   = IW'(i_p[LEN-1:0]);
    assign w_sum = w_h * IW'(C) + w_l;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= 1'b0;
            r_p   <= '0;
        end else begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_p <= w_sum;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_p   = r_p;

endmodule

// File: rtl/bsmodmul_pm.sv
// Bit-serial (A serial, B parallel) multiplier modulo p = 2^LEN - C with a fixed
// LEN+3 cycle latency and back-to-back frame support.
module bsmodmul_pm
    import bsmod_pkg::*;
#(
    parameter int unsigned LEN = 24,
    parameter int unsigned C   = 3
) (
    input  logic         clk,
    input  logic         reset,
    bsmodmul_pm_if.slave io_bus
);

    localparam int unsigned   IW    = fold_width(LEN, C);
    localparam int unsigned   CW    = $clog2(LEN + 1);
    localparam logic [IW-1:0] P_MOD = (IW'(1) << LEN) - IW'(C);

    if (!modulus_ok(LEN, C)) begin : g_bad_param
        $error("bsmodmul_pm: LEN must be 8..64 and 1 <= C < 2^(LEN/2-1)");
    end

    // ------------------------------------------------------------------
    // Input FSM: r_cnt is the index of the current input cycle (1..LEN);
    // cycle LEN of a frame is the hand-off cycle where the product is ready.
    // ------------------------------------------------------------------
    acc_state_e    r_state;
    acc_state_e    w_state_d;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;
    logic          w_in_frame;
    logic          w_start;
    logic          w_abort;
    logic          w_take;
    logic          w_prod_vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (io_bus.isync) begin
                    w_state_d = StAcc;
                    w_cnt_d   = CW'(1);
                end
            end
            StAcc: begin
                if (io_bus.isync) begin
                    w_state_d = StAcc;
                    w_cnt_d   = CW'(1);
                end else if (r_cnt == CW'(LEN)) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        w_in_frame = (r_state == StAcc) && (r_cnt != CW'(LEN));
        w_start    = io_bus.isync;
        w_abort    = io_bus.isync && w_in_frame;
        w_take     = io_bus.isync || w_in_frame;
        w_prod_vld = (r_state == StAcc) && (r_cnt == CW'(LEN));
    end

    assign io_bus.ferr = w_abort;

    // ------------------------------------------------------------------
    // Shift-and-add accumulator; r_bsh holds B << i for the next A bit.
    // A new frame restarts from zero, which also discards an aborted one.
    // ------------------------------------------------------------------
    logic [2*LEN-1:0] r_acc;
    logic [2*LEN-1:0] r_bsh;
    logic [2*LEN-1:0] w_bsh_cur;
    logic [2*LEN-1:0] w_acc_base;
    logic [2*LEN-1:0] w_addend;

    always_comb begin
        w_bsh_cur  = w_start ? {{LEN{1'b0}}, io_bus.b} : r_bsh;
        w_acc_base = w_start ? '0 : r_acc;
        w_addend   = io_bus.a ? w_bsh_cur : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
            r_bsh <= '0;
        end else if (w_take) begin
            r_acc <= w_acc_base + w_addend;
            r_bsh <= w_bsh_cur << 1;
        end
    end

    // ------------------------------------------------------------------
    // Two folds bring the product below 2p; one conditional subtract finishes.
    // ------------------------------------------------------------------
    logic             w_f1_vld;
    logic [IW-1:0]    w_f1_p;
    logic [2*LEN-1:0] w_f1_ext;
    logic             w_f2_vld;
    logic [IW-1:0]    w_f2_p;
    logic [LEN-1:0]   w_red;

    bsfold #(
        .LEN (LEN),
        .C   (C),
        .IW  (IW)
    ) u_fold1 (
        .clk   (clk),
        .reset (reset),
        .i_vld (w_prod_vld),
        .i_p   (r_acc),
        .o_vld (w_f1_vld),
        .o_p   (w_f1_p)
    );

    assign w_f1_ext = (2*LEN)'(w_f1_p);

    bsfold #(
        .LEN (LEN),
        .C   (C),
        .IW  (IW)
    ) u_fold2 (
        .clk   (clk),
        .reset (reset),
        .i_vld (w_f1_vld),
        .i_p   (w_f1_ext),
        .o_vld (w_f2_vld),
        .o_p   (w_f2_p)
    );

    assign w_red = LEN'((w_f2_p >= P_MOD) ? (w_f2_p - P_MOD) : w_f2_p);

    // ------------------------------------------------------------------
    // Output shift register; the subtract result is loaded directly so bit 0
    // appears in cycle LEN+3. A load in the last bit cycle abuts frames.
    // ------------------------------------------------------------------
    logic [LEN-1:0] r_sh;
    logic [CW-1:0]  r_ocnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sh   <= '0;
            r_ocnt <= '0;
        end else if (w_f2_vld) begin
            r_sh   <= w_red;
            r_ocnt <= CW'(LEN);
        end else if (r_ocnt != '0) begin
            r_sh   <= r_sh >> 1;
            r_ocnt <= r_ocnt - CW'(1);
        end
    end

    assign io_bus.ovld  = (r_ocnt != '0);
    assign io_bus.osync = (r_ocnt == CW'(LEN));
    assign io_bus.q     = io_bus.ovld & r_sh[0];

endmodule

// File: doc/bsmodmul_pm.md
BSMODMUL_PM -- requirements
Module: bsmodmul_pm

Interface
REQ-001 Parameter LEN, default 24: operand/result width in bits; legal range 8..64.
REQ-002 Parameter C, default 3: modulus constant, p = 2^LEN - C; legal range 1 <= C < 2^(LEN/2-1); elaboration fails otherwise.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 a  input  1  serial operand A, LSB first, one bit per cycle.
REQ-006 b  input  LEN  parallel operand B, sampled only in the isync cycle.
REQ-007 isync  input  1  high in the cycle carrying A bit 0; starts an input frame.
REQ-008 q  output  1  serial result, LSB first.
REQ-009 osync  output  1  high in the cycle carrying result bit 0.
REQ-010 ovld  output  1  high for all LEN cycles of an output frame.
REQ-011 ferr  output  1  one-cycle pulse flagging an aborted input frame.

Function
REQ-012 Result SHALL be (A*B) mod p, fully reduced into 0..p-1, for any A, B in 0..2^LEN-1 (inputs >= p legal).
REQ-013 Input frame: cycle 0 = isync cycle; A bit i is sampled in cycle i, i = 0..LEN-1.
REQ-014 Latency SHALL be fixed: osync and result bit 0 in cycle LAT = LEN+3; result bit i in cycle LAT+i.
REQ-015 Pipeline stages: accumulate (cycles 0..LEN-1), fold 1 (P = H*2^LEN + L -> H*C + L), fold 2 (same), conditional subtract of p; one registered stage each.
REQ-016 Product accumulator SHALL be 2*LEN bits wide; fold intermediates LEN + ceil(log2(C+1)) + 1 bits wide; no truncation before final subtract.
REQ-017 Back-to-back frames SHALL be supported: isync in cycle LEN of a frame starts the next frame with no gap; output frames then also abut, osync every LEN cycles.
REQ-018 Input FSM states IDLE and ACC; IDLE->ACC on isync; ACC->IDLE after bit LEN-1 unless isync coincides; ACC->ACC on isync at bit LEN-1 boundary (cycle LEN).
REQ-019 isync in ACC at input cycle k, 1 <= k <= LEN-1: current frame SHALL be discarded, ferr pulses in that cycle, new frame starts with k treated as cycle 0.
REQ-020 Aborted frames SHALL produce no output; frames already in fold/subtract/output stages SHALL complete unaffected.
REQ-021 a and b SHALL be ignored in IDLE; b changes after the isync cycle SHALL NOT affect that frame.
REQ-022 Outside output frames q = 0, osync = 0, ovld = 0.
REQ-023 Result 0 (e.g. A = p) SHALL be emitted as LEN zero bits with osync/ovld asserted normally.

Reset
REQ-024 reset low SHALL immediately force q, osync, ovld, ferr to 0 and input FSM to IDLE, independent of clk.
REQ-025 reset low SHALL invalidate every in-flight frame at any stage; no output frame appears after release until a new isync.
REQ-026 First isync is honoured in the first rising edge with reset high.

Structure
REQ-027 Shared package bsmod_pkg SHALL hold LAT(LEN) latency function, width helper for fold intermediates, and modulus-legality check function.
REQ-028 One sub-module bsfold (parameters LEN, C, IW; registered H*C + L fold) SHALL be instantiated twice.
REQ-029 Output stage SHALL be a LEN-bit shift register with a frame-valid counter driving osync/ovld.

Verification
REQ-030 LEN=24,C=3: A=2, B=3 -> q frame = 6, osync exactly 27 cycles after isync.
REQ-031 LEN=24,C=3: A=0x800000, B=2 -> 3; A=0xFFFFFF, B=1 -> 2; A=16777212, B=16777212 -> 1.
REQ-032 LEN=16,C=15: A=0xFFFF, B=0xFFFF -> 196; A=65521, B=0x1234 -> 0 with osync/ovld asserted.
REQ-033 Three back-to-back frames (isync every 24 cycles) -> three abutting output frames, osync every 24 cycles, correct values.
REQ-034 isync at cycle 5 of a frame -> ferr pulse that cycle, only the second frame's result appears, at LAT after second isync.
REQ-035 reset low during output bit 10 -> q/osync/ovld 0 immediately, no residual output after release; next frame correct.
